// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: OUT/DIR with atomic set/clear/toggle, synchronised inputs, edge interrupts.
// Edge-interrupt logic (EN_RISE, EN_FALL, PEND, irq) is built only when GPIO_IRQ_EN is defined.
module mmio_gpio_bank #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h1200_0000,
  parameter logic [31:0] RESET_OUT   = 32'h0000_00F9,
  parameter logic [31:0] RESET_DIR   = 32'h0000_00FF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_wdata,
  output logic [31:0]      mem_rdata,
  output logic             mem_ready,
  output logic             sel,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [3:0] REG_OUT     = 4'h0;
  localparam logic [3:0] REG_SET     = 4'h1;
  localparam logic [3:0] REG_CLR     = 4'h2;
  localparam logic [3:0] REG_TGL     = 4'h3;
  localparam logic [3:0] REG_DIR     = 4'h4;
  localparam logic [3:0] REG_IN      = 4'h5;
  localparam logic [3:0] REG_EN_RISE = 4'h6;
  localparam logic [3:0] REG_EN_FALL = 4'h7;
  localparam logic [3:0] REG_PEND    = 4'h8;
  localparam logic [3:0] REG_INFO    = 4'h9;

  logic [WIDTH-1:0] out_q, dir_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] en_rise_q, en_fall_q, pend_q;
  logic             accept, write_en, has_irq;
  logic [3:0]       reg_idx;
  logic [31:0]      lane_mask, wbits32, rd_val;
  logic [WIDTH-1:0] lane_w, wbits;
  logic             unused_bits;

  assign sel       = (mem_addr[31:6] == BASE_ADDR[31:6]);
  assign accept    = mem_valid & sel & ~mem_ready;
  assign write_en  = accept & (mem_wstrb != 4'b0000);
  assign reg_idx   = mem_addr[5:2];
  assign lane_mask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  assign wbits32   = mem_wdata & lane_mask;
  assign lane_w    = lane_mask[WIDTH-1:0];
  assign wbits     = wbits32[WIDTH-1:0];
  assign sync_in   = sync_q[SYNC_STAGES-1];
  assign gpio_out  = out_q;
  assign gpio_oe   = dir_q;

  assign unused_bits = ^{mem_addr[1:0], wbits32, lane_mask};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= RESET_OUT[WIDTH-1:0];
      dir_q <= RESET_DIR[WIDTH-1:0];
    end else if (write_en) begin
      case (reg_idx)
        REG_OUT: out_q <= (out_q & ~lane_w) | wbits;
        REG_SET: out_q <= out_q | wbits;
        REG_CLR: out_q <= out_q & ~wbits;
        REG_TGL: out_q <= out_q ^ wbits;
        REG_DIR: dir_q <= (dir_q & ~lane_w) | wbits;
        default: ;
      endcase
    end
  end

  // Pins are asynchronous; only the last stage is used by IN and the edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] prev_q, rise, fall, pend_set;

  assign rise     = sync_in & ~prev_q;
  assign fall     = ~sync_in & prev_q;
  assign pend_set = (rise & en_rise_q) | (fall & en_fall_q);
  assign irq      = |pend_q;
  assign has_irq  = 1'b1;

  // A fresh edge in the same cycle as a W1C keeps the pending bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= '0;
      en_rise_q <= '0;
      en_fall_q <= '0;
      pend_q    <= '0;
    end else begin
      prev_q <= sync_in;
      if (write_en && reg_idx == REG_EN_RISE) en_rise_q <= (en_rise_q & ~lane_w) | wbits;
      if (write_en && reg_idx == REG_EN_FALL) en_fall_q <= (en_fall_q & ~lane_w) | wbits;
      if (write_en && reg_idx == REG_PEND) pend_q <= (pend_q & ~wbits) | pend_set;
      else                                 pend_q <= pend_q | pend_set;
    end
  end
`else
  assign en_rise_q = '0;
  assign en_fall_q = '0;
  assign pend_q    = '0;
  assign irq       = 1'b0;
  assign has_irq   = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_OUT, REG_SET, REG_CLR, REG_TGL: rd_val[WIDTH-1:0] = out_q;
      REG_DIR:     rd_val[WIDTH-1:0] = dir_q;
      REG_IN:      rd_val[WIDTH-1:0] = sync_in;
      REG_EN_RISE: rd_val[WIDTH-1:0] = en_rise_q;
      REG_EN_FALL: rd_val[WIDTH-1:0] = en_fall_q;
      REG_PEND:    rd_val[WIDTH-1:0] = pend_q;
      REG_INFO:    rd_val = {23'h0, has_irq, 8'(WIDTH)};
      default:     ;
    endcase
  end

  // Ready is high only in the cycle after an accept, which also blocks back-to-back accepts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= accept ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Self-checking bench for mmio_gpio_bank (WIDTH = 8) with a behavioural register model.
// Edge-interrupt scenarios are exercised only when GPIO_IRQ_EN is defined.
module tb_mmio_gpio_bank;

  localparam logic [31:0] BASE = 32'h1200_0000;
`ifdef GPIO_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        sel;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        irq;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_out, m_dir, m_en_r, m_en_f, m_pend, m_pin;

  mmio_gpio_bank dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .sel(sel), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  // One bus access; lat = cycles from drive to ready (0 = none within budget, -1 = ready held too long).
  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
    lat = 0;
    rd  = '0;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = addr; mem_wstrb = strb; mem_wdata = wd;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) begin
        lat = i;
        rd  = mem_rdata;
        break;
      end
    end
    mem_valid = 1'b0; mem_wstrb = '0;
    @(posedge clk); #1;
    if (mem_ready !== 1'b0) lat = -1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_valid = 1'b0;
    gpio_in   = '0;
    reset     = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(4);
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] idx);
    case (idx)
      4'h0, 4'h1, 4'h2, 4'h3: return {24'h0, m_out};
      4'h4: return {24'h0, m_dir};
      4'h5: return {24'h0, m_pin};
      4'h6: return HAS_IRQ ? {24'h0, m_en_r} : 32'h0;
      4'h7: return HAS_IRQ ? {24'h0, m_en_f} : 32'h0;
      4'h8: return HAS_IRQ ? {24'h0, m_pend} : 32'h0;
      4'h9: return {23'h0, HAS_IRQ, 8'd8};
      default: return 32'h0;
    endcase
  endfunction

  // With 8 pins only byte lane 0 carries register bits.
  task automatic model_write(input logic [3:0] idx, input logic [3:0] strb, input logic [31:0] wd);
    logic [7:0] b;
    if (strb[0]) begin
      b = wd[7:0];
      case (idx)
        4'h0: m_out = b;
        4'h1: m_out = m_out | b;
        4'h2: m_out = m_out & ~b;
        4'h3: m_out = m_out ^ b;
        4'h4: m_dir = b;
        4'h6: if (HAS_IRQ) m_en_r = b;
        4'h7: if (HAS_IRQ) m_en_f = b;
        4'h8: if (HAS_IRQ) m_pend = m_pend & ~b;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    gpio_in = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (gpio_out !== 8'hF9) begin failures++; $display("[TB] FAIL reset_out got=%h exp=f9", gpio_out); end
    checks++; if (gpio_oe !== 8'hFF) begin failures++; $display("[TB] FAIL reset_oe got=%h exp=ff", gpio_oe); end
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (mem_ready !== 1'b0 || mem_rdata !== 32'h0)
      begin failures++; $display("[TB] FAIL reset_bus got ready=%b rdata=%h exp 0/0", mem_ready, mem_rdata); end
    reset = 1'b0;
    bus_xfer(BASE + 32'h24, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== {23'h0, HAS_IRQ, 8'd8} || lat != 1)
      begin failures++; $display("[TB] FAIL reset_info got=%h lat=%0d exp=%h lat=1", rd, lat, {23'h0, HAS_IRQ, 8'd8}); end
  endtask

  task automatic test_atomics();
    logic [31:0] rd;
    int lat;
    logic [3:0]  idx_t [4] = '{4'h0, 4'h1, 4'h2, 4'h3};
    logic [31:0] dat_t [4] = '{32'h0F, 32'h30, 32'h01, 32'h81};
    for (int i = 0; i < 4; i++) begin
      bus_xfer(BASE + {26'h0, idx_t[i], 2'b00}, 4'hF, dat_t[i], rd, lat);
      checks++; if (lat != 1) begin failures++; $display("[TB] FAIL atomics_ready step=%0d lat=%0d exp=1", i, lat); end
    end
    bus_xfer(BASE + 32'h00, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'hBF) begin failures++; $display("[TB] FAIL atomics_out got=%h exp=000000bf", rd); end
    checks++; if (gpio_out !== 8'hBF) begin failures++; $display("[TB] FAIL atomics_pin got=%h exp=bf", gpio_out); end
    bus_xfer(BASE + 32'h0C, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'hBF) begin failures++; $display("[TB] FAIL alias_read got=%h exp=000000bf", rd); end
  endtask

  task automatic test_strobes();
    logic [31:0] rd;
    int lat;
    bus_xfer(BASE + 32'h10, 4'b0100, 32'hAABBCCDD, rd, lat);
    bus_xfer(BASE + 32'h10, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'hFF) begin failures++; $display("[TB] FAIL strobe_lane2 got=%h exp=000000ff", rd); end
    bus_xfer(BASE + 32'h10, 4'b0001, 32'hAABBCCDD, rd, lat);
    bus_xfer(BASE + 32'h10, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'hDD || gpio_oe !== 8'hDD)
      begin failures++; $display("[TB] FAIL strobe_lane0 got=%h oe=%h exp=000000dd", rd, gpio_oe); end
    bus_xfer(BASE + 32'h00, 4'hF, 32'hFFFFFFFF, rd, lat);
    bus_xfer(BASE + 32'h00, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'hFF) begin failures++; $display("[TB] FAIL strobe_upper got=%h exp=000000ff", rd); end
  endtask

  task automatic test_in_latency();
    logic [31:0] rd;
    int lat;
    gpio_in = 8'h00;
    wait_cycles(4);
    gpio_in = 8'h5A;
    bus_xfer(BASE + 32'h14, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'h00) begin failures++; $display("[TB] FAIL in_early got=%h exp=00000000", rd); end
    bus_xfer(BASE + 32'h14, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'h5A) begin failures++; $display("[TB] FAIL in_value got=%h exp=0000005a", rd); end
  endtask

  task automatic test_window();
    logic [31:0] rd;
    int lat;
    bus_xfer(BASE + 32'h00, 4'hF, 32'h12, rd, lat);
    bus_xfer(BASE + 32'h28, 4'hF, 32'hFFFFFFFF, rd, lat);
    checks++; if (lat != 1) begin failures++; $display("[TB] FAIL reserved_ready lat=%0d exp=1", lat); end
    bus_xfer(BASE + 32'h00, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'h12) begin failures++; $display("[TB] FAIL reserved_ignored got=%h exp=00000012", rd); end
    bus_xfer(BASE + 32'h3C, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0 || lat != 1)
      begin failures++; $display("[TB] FAIL reserved_read got=%h lat=%0d exp=0 lat=1", rd, lat); end
    mem_addr = BASE + 32'h40; #1;
    checks++; if (sel !== 1'b0) begin failures++; $display("[TB] FAIL sel_outside got=%b exp=0", sel); end
    mem_addr = BASE + 32'h3C; #1;
    checks++; if (sel !== 1'b1) begin failures++; $display("[TB] FAIL sel_inside got=%b exp=1", sel); end
    bus_xfer(BASE + 32'h40, 4'h0, 32'h0, rd, lat);
    checks++; if (lat != 0) begin failures++; $display("[TB] FAIL outside_ready lat=%0d exp=0", lat); end
    checks++; if (mem_rdata !== 32'h0) begin failures++; $display("[TB] FAIL idle_rdata got=%h exp=0", mem_rdata); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = BASE; mem_wstrb = 4'hF; mem_wdata = 32'h55;
    #3 reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_ready !== 1'b0 || gpio_out !== 8'hF9)
      begin failures++; $display("[TB] FAIL reset_mid got ready=%b out=%h exp 0/f9", mem_ready, gpio_out); end
    mem_valid = 1'b0; mem_wstrb = '0; reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid_after got=%b exp=0", mem_ready); end
    bus_xfer(BASE, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'hF9 || lat != 1)
      begin failures++; $display("[TB] FAIL post_reset_read got=%h lat=%0d exp=f9 lat=1", rd, lat); end
  endtask

`ifdef GPIO_IRQ_EN
  task automatic test_edge_irq();
    logic [31:0] rd;
    int lat;
    gpio_in = '0;
    wait_cycles(4);
    bus_xfer(BASE + 32'h20, 4'hF, 32'hFF, rd, lat);
    bus_xfer(BASE + 32'h18, 4'hF, 32'h04, rd, lat);
    @(posedge clk); #1;
    gpio_in[2] = 1'b1;
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL irq_cycle1 got=%b exp=0", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL irq_cycle2 got=%b exp=0", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_cycle3 got=%b exp=1", irq); end
    bus_xfer(BASE + 32'h20, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'h04) begin failures++; $display("[TB] FAIL pend_rise got=%h exp=00000004", rd); end
    bus_xfer(BASE + 32'h20, 4'hF, 32'h04, rd, lat);
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL irq_clear got=%b exp=0", irq); end
    gpio_in[2] = 1'b0;
    wait_cycles(5);
    bus_xfer(BASE + 32'h20, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0 || irq !== 1'b0)
      begin failures++; $display("[TB] FAIL fall_ignored got=%h irq=%b exp=0/0", rd, irq); end
  endtask

  task automatic test_set_wins();
    logic [31:0] rd;
    int lat;
    gpio_in[2] = 1'b1;
    wait_cycles(5);
    gpio_in[2] = 1'b0;
    wait_cycles(5);
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL setwins_pre got=%b exp=1", irq); end
    @(posedge clk); #1;
    gpio_in[2] = 1'b1;
    @(posedge clk);
    bus_xfer(BASE + 32'h20, 4'hF, 32'h04, rd, lat);
    bus_xfer(BASE + 32'h20, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'h04 || irq !== 1'b1)
      begin failures++; $display("[TB] FAIL set_wins got=%h irq=%b exp=00000004/1", rd, irq); end
  endtask
`else
  task automatic test_no_irq();
    logic [31:0] rd;
    int lat;
    bus_xfer(BASE + 32'h18, 4'hF, 32'hFF, rd, lat);
    bus_xfer(BASE + 32'h1C, 4'hF, 32'hFF, rd, lat);
    gpio_in = 8'hFF;
    wait_cycles(5);
    gpio_in = 8'h00;
    wait_cycles(5);
    bus_xfer(BASE + 32'h20, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0 || lat != 1)
      begin failures++; $display("[TB] FAIL noirq_pend got=%h lat=%0d exp=0 lat=1", rd, lat); end
    bus_xfer(BASE + 32'h18, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL noirq_en got=%h exp=0", rd); end
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL noirq_irq got=%b exp=0", irq); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] rd, exp, addr, wd;
    logic [3:0]  idx, strb;
    logic [7:0]  new_pin;
    int lat;
    do_reset();
    m_out = 8'hF9; m_dir = 8'hFF; m_en_r = '0; m_en_f = '0; m_pend = '0; m_pin = '0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 99) < 15) begin
        new_pin = 8'($urandom);
        @(posedge clk); #1;
        gpio_in = new_pin;
        wait_cycles(5);
        if (HAS_IRQ) m_pend = m_pend | ((new_pin & ~m_pin) & m_en_r) | ((m_pin & ~new_pin) & m_en_f);
        m_pin = new_pin;
      end else begin
        idx  = 4'($urandom_range(0, 15));
        addr = BASE + {26'h0, idx, 2'($urandom_range(0, 3))};
        strb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        wd   = $urandom;
        exp  = model_read(idx);
        bus_xfer(addr, strb, wd, rd, lat);
        checks++; if (lat != 1) begin failures++; $display("[TB] FAIL rand_ready op=%0d lat=%0d exp=1", n, lat); end
        if (strb == 4'h0) begin
          checks++; if (rd !== exp)
            begin failures++; $display("[TB] FAIL rand_read op=%0d idx=%0d got=%h exp=%h", n, idx, rd, exp); end
        end
        model_write(idx, strb, wd);
      end
      checks++; if (gpio_out !== m_out || gpio_oe !== m_dir || irq !== (m_pend != 8'h0))
        begin failures++; $display("[TB] FAIL rand_pins op=%0d out=%h oe=%h irq=%b exp=%h %h %b",
                                   n, gpio_out, gpio_oe, irq, m_out, m_dir, (m_pend != 8'h0)); end
    end
  endtask

  initial begin
    test_reset();
    test_atomics();
    test_strobes();
    test_in_latency();
    test_window();
    test_reset_mid();
`ifdef GPIO_IRQ_EN
    test_edge_irq();
    test_set_wins();
`else
    test_no_irq();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
